cacheline_burst_adapter: RTL and testbench

- Sits between the L1 caches' 256-bit physical-memory port and the 64-bit burst main memory.
- Acts as the responder to the cache's pmem read/write/resp interface.
- Acts as the initiator of 4-beat bursts toward memory.
- Each line read is assembled from beats; each line write (writeback) is split into beats.

---
 rtl/cacheline_burst_adapter_if.sv | 40 ++++
 rtl/cacheline_burst_adapter.sv | 122 ++++++++++++
 tb/tb_cacheline_burst_adapter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_burst_adapter_if
// Description : Bundles the cache-side line port and the memory-side burst
//               port of the cache-line burst adapter.
//               slave  = adapter view
//               master = environment view (cache + memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface cacheline_burst_adapter_if #(
    parameter int S_LINE = 256,
    parameter int S_BEAT = 64
);
    // Cache side
    logic [S_LINE-1:0] line_i;
    logic [S_LINE-1:0] line_o;
    logic [31:0]       address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;

    // Memory side
    logic [S_BEAT-1:0] burst_i;
    logic [S_BEAT-1:0] burst_o;
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface
`default_nettype wire

// File: rtl/cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_burst_adapter
// Description : Converts single full-line cache requests into fixed-length
//               beat bursts toward main memory. Reads assemble a line from
//               beats; writebacks split the latched line into beats.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_burst_adapter #(
    parameter int S_LINE    = 256,
    parameter int S_BEAT    = 64,
    parameter int NUM_BEATS = S_LINE / S_BEAT,
    parameter int S_OFFSET  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    cacheline_burst_adapter_if.slave  bus
);

    localparam int c_beat_w = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(NUM_BEATS - 1);
    localparam logic [31:0] c_align_mask = ~((32'd1 << S_OFFSET) - 32'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_beat_w-1:0]   r_beat;
    logic [S_LINE-1:0]     r_line_wr;
    logic [S_LINE-1:0]     r_line_rd;
    logic [31:0]           r_addr;
    logic                  r_read;
    logic                  r_write;
    logic                  r_resp;

    logic [S_BEAT-1:0]     w_wr_beats [NUM_BEATS];

    // Slice the latched writeback line into per-beat views for the beat mux
    generate
        for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_wr_beat
            assign w_wr_beats[gi] = r_line_wr[gi*S_BEAT +: S_BEAT];
        end
    endgenerate

    // Transfer sequencer: one request per visit to IDLE, registered strobes.
    // Requests are only sampled in IDLE, and DONE always returns to IDLE so a
    // request still held during the resp_o cycle is never serviced twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_line_wr <= '0;
            r_line_rd <= '0;
            r_addr    <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_resp    <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Writeback has priority; a concurrent read stays pending
                    // in the cache and is picked up on a later IDLE cycle.
                    if (bus.write_i) begin
                        r_line_wr <= bus.line_i;
                        r_addr    <= bus.address_i & c_align_mask;
                        r_write   <= 1'b1;
                        r_state   <= WR_BURST;
                    end else if (bus.read_i) begin
                        r_addr    <= bus.address_i & c_align_mask;
                        r_read    <= 1'b1;
                        r_state   <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (bus.resp_i) begin
                        r_line_rd[int'(r_beat)*S_BEAT +: S_BEAT] <= bus.burst_i;
                        if (r_beat == c_last_beat) begin
                            r_beat  <= '0;
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.resp_i) begin
                        if (r_beat == c_last_beat) begin
                            r_beat  <= '0;
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.line_o    = r_line_rd;
    assign bus.address_o = r_addr;
    assign bus.read_o    = r_read;
    assign bus.write_o   = r_write;
    assign bus.resp_o    = r_resp;
    assign bus.burst_o   = w_wr_beats[r_beat];

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_burst_adapter
// Description : Self-checking bench for cacheline_burst_adapter with a
//               scripted memory responder and queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_adapter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cacheline_burst_adapter_if ifc ();

    cacheline_burst_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory model data and scoreboard queues
    logic [63:0]  rd_beats [4];
    logic [63:0]  exp_beats [$];
    logic [63:0]  obs_beats [$];
    logic [63:0]  obs_stall [$];
    logic [255:0] exp_lines [$];
    logic [255:0] obs_lines [$];
    int           resp_cyc [$];

    int          n_resp;
    int          lat;
    int          rd_cycles;
    int          wr_cycles;
    bit          overlap;
    bit          first_wr;
    logic [31:0] obs_addr;

    // Memory responder: runs at negedges, answers bursts, optionally stalls
    // before beat stall_beat, records what the DUT presents.
    task automatic mem_run(input int stall_beat, input int stall_len,
                           input int target, input bit late_drop);
        int beat_idx   = 0;
        int stall_used = 0;
        int cyc        = 0;
        bit last_wr    = 1'b0;
        bit started    = 1'b0;
        n_resp = 0; lat = 0; rd_cycles = 0; wr_cycles = 0;
        overlap = 1'b0; first_wr = 1'b0; obs_addr = '0;
        resp_cyc.delete();
        while (n_resp < target && cyc < 100) begin
            @(negedge clk);
            cyc++;
            ifc.resp_i = 1'b0;
            if (ifc.read_o && ifc.write_o) overlap = 1'b1;
            if (ifc.read_o)  rd_cycles++;
            if (ifc.write_o) wr_cycles++;
            if (ifc.resp_o) begin
                n_resp++;
                resp_cyc.push_back(cyc);
                if (n_resp == 1) lat = cyc + 1;
                if (!last_wr) obs_lines.push_back(ifc.line_o);
                if (last_wr) ifc.write_i = 1'b0;
                else if (!late_drop) ifc.read_i = 1'b0;
                beat_idx   = 0;
                stall_used = 0;
            end else if (ifc.read_o || ifc.write_o) begin
                if (!started) begin
                    started  = 1'b1;
                    first_wr = ifc.write_o;
                    obs_addr = ifc.address_o;
                end
                last_wr = ifc.write_o;
                if (beat_idx == stall_beat && stall_used < stall_len) begin
                    stall_used++;
                    if (ifc.write_o) obs_stall.push_back(ifc.burst_o);
                end else begin
                    ifc.resp_i  = 1'b1;
                    ifc.burst_i = (beat_idx < 4) ? rd_beats[beat_idx] : 64'h0;
                    if (ifc.write_o) obs_beats.push_back(ifc.burst_o);
                    beat_idx++;
                end
            end
        end
        ifc.resp_i = 1'b0;
    endtask

    task automatic test_reset();
        ifc.line_i = '0; ifc.address_i = '0; ifc.read_i = 1'b0;
        ifc.write_i = 1'b0; ifc.burst_i = '0; ifc.resp_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ifc.read_o !== 1'b0) begin bad++; $display("FAIL reset_read_o: got %b want 0", ifc.read_o); end
        total++; if (ifc.write_o !== 1'b0) begin bad++; $display("FAIL reset_write_o: got %b want 0", ifc.write_o); end
        total++; if (ifc.resp_o !== 1'b0) begin bad++; $display("FAIL reset_resp_o: got %b want 0", ifc.resp_o); end
        total++; if (ifc.line_o !== 256'h0) begin bad++; $display("FAIL reset_line_o: got %h want 0", ifc.line_o); end
        total++; if (ifc.burst_o !== 64'h0) begin bad++; $display("FAIL reset_burst_o: got %h want 0", ifc.burst_o); end
        total++; if (ifc.address_o !== 32'h0) begin bad++; $display("FAIL reset_address_o: got %h want 0", ifc.address_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_b2b();
        logic [255:0] got;
        rd_beats[0] = 64'h1111_1111_1111_1111; rd_beats[1] = 64'h2222_2222_2222_2222;
        rd_beats[2] = 64'h3333_3333_3333_3333; rd_beats[3] = 64'h4444_4444_4444_4444;
        exp_lines.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        ifc.address_i = 32'h0000_1234;
        ifc.read_i    = 1'b1;
        mem_run(-1, 0, 1, 1'b0);
        total++; if (n_resp !== 1) begin bad++; $display("FAIL rd_resp_count: got %0d want 1", n_resp); end
        total++; if (obs_addr !== 32'h0000_1220) begin bad++; $display("FAIL rd_address_o: got %h want 00001220", obs_addr); end
        total++; if (rd_cycles !== 4) begin bad++; $display("FAIL rd_read_o_cycles: got %0d want 4", rd_cycles); end
        total++; if (lat !== 6) begin bad++; $display("FAIL rd_latency: got %0d want 6", lat); end
        if (obs_lines.size() > 0 && exp_lines.size() > 0) begin
            got = obs_lines.pop_front();
            total++; if (got !== exp_lines[0]) begin bad++; $display("FAIL rd_line_o: got %h want %h", got, exp_lines[0]); end
            void'(exp_lines.pop_front());
        end else begin
            total++; bad++; $display("FAIL rd_line_missing: got %0d lines want 1", obs_lines.size());
            exp_lines.delete();
        end
        @(negedge clk);
        total++; if (ifc.resp_o !== 1'b0) begin bad++; $display("FAIL rd_resp_single: got %b want 0", ifc.resp_o); end
        total++; if (ifc.read_o !== 1'b0) begin bad++; $display("FAIL rd_read_o_after: got %b want 0", ifc.read_o); end
    endtask

    task automatic test_write_stall();
        logic [63:0] b [4];
        logic [63:0] g;
        b[0] = 64'hAAAA_AAAA_AAAA_AAAA; b[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        b[2] = 64'hCCCC_CCCC_CCCC_CCCC; b[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        for (int i = 0; i < 4; i++) exp_beats.push_back(b[i]);
        obs_beats.delete(); obs_stall.delete();
        ifc.line_i    = {b[3], b[2], b[1], b[0]};
        ifc.address_i = 32'h8000_00FF;
        ifc.write_i   = 1'b1;
        mem_run(2, 2, 1, 1'b0);
        total++; if (n_resp !== 1) begin bad++; $display("FAIL wr_resp_count: got %0d want 1", n_resp); end
        total++; if (obs_addr !== 32'h8000_00E0) begin bad++; $display("FAIL wr_address_o: got %h want 800000e0", obs_addr); end
        total++; if (lat !== 8) begin bad++; $display("FAIL wr_latency: got %0d want 8", lat); end
        total++; if (wr_cycles !== 6) begin bad++; $display("FAIL wr_write_o_cycles: got %0d want 6", wr_cycles); end
        total++; if (obs_beats.size() !== 4) begin bad++; $display("FAIL wr_beat_count: got %0d want 4", obs_beats.size()); end
        for (int i = 0; i < 4; i++) begin
            if (obs_beats.size() > 0) begin
                g = obs_beats.pop_front();
                total++; if (g !== exp_beats[0]) begin bad++; $display("FAIL wr_beat%0d: got %h want %h", i, g, exp_beats[0]); end
            end
            void'(exp_beats.pop_front());
        end
        total++; if (obs_stall.size() !== 2) begin bad++; $display("FAIL wr_stall_cycles: got %0d want 2", obs_stall.size()); end
        while (obs_stall.size() > 0) begin
            g = obs_stall.pop_front();
            total++; if (g !== b[2]) begin bad++; $display("FAIL wr_stall_hold: got %h want %h", g, b[2]); end
        end
        total++; if (ifc.line_o !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111})
            begin bad++; $display("FAIL wr_line_o_kept: got %h", ifc.line_o); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] b [4];
        logic [63:0] g;
        logic [255:0] gl;
        b[0] = 64'h0123_4567_89AB_CDEF; b[1] = 64'hFEDC_BA98_7654_3210;
        b[2] = 64'h0F0F_0F0F_F0F0_F0F0; b[3] = 64'h5A5A_A5A5_5A5A_A5A5;
        for (int i = 0; i < 4; i++) exp_beats.push_back(b[i]);
        rd_beats[0] = 64'h9000_0000_0000_0009; rd_beats[1] = 64'h8000_0000_0000_0008;
        rd_beats[2] = 64'h7000_0000_0000_0007; rd_beats[3] = 64'h6000_0000_0000_0006;
        exp_lines.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        obs_beats.delete(); obs_lines.delete();
        ifc.line_i    = {b[3], b[2], b[1], b[0]};
        ifc.address_i = 32'h0000_0040;
        ifc.read_i    = 1'b1;
        ifc.write_i   = 1'b1;
        mem_run(-1, 0, 2, 1'b0);
        total++; if (n_resp !== 2) begin bad++; $display("FAIL b2b_resp_count: got %0d want 2", n_resp); end
        total++; if (first_wr !== 1'b1) begin bad++; $display("FAIL b2b_write_first: got %b want 1", first_wr); end
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL b2b_overlap: got %b want 0", overlap); end
        total++; if (rd_cycles !== 4 || wr_cycles !== 4) begin bad++; $display("FAIL b2b_burst_cycles: got rd=%0d wr=%0d want 4/4", rd_cycles, wr_cycles); end
        if (resp_cyc.size() == 2) begin
            total++; if (resp_cyc[1] - resp_cyc[0] !== 6) begin bad++; $display("FAIL b2b_resp_gap: got %0d want 6", resp_cyc[1] - resp_cyc[0]); end
        end
        for (int i = 0; i < 4; i++) begin
            if (obs_beats.size() > 0) begin
                g = obs_beats.pop_front();
                total++; if (g !== exp_beats[0]) begin bad++; $display("FAIL b2b_wbeat%0d: got %h want %h", i, g, exp_beats[0]); end
            end
            void'(exp_beats.pop_front());
        end
        if (obs_lines.size() > 0) begin
            gl = obs_lines.pop_front();
            total++; if (gl !== exp_lines[0]) begin bad++; $display("FAIL b2b_line_o: got %h want %h", gl, exp_lines[0]); end
        end else begin
            total++; bad++; $display("FAIL b2b_line_missing: got 0 lines want 1");
        end
        exp_lines.delete();
        @(negedge clk);
    endtask

    task automatic test_held_request();
        logic [255:0] gl;
        rd_beats[0] = 64'hA0A0_0000_0000_0001; rd_beats[1] = 64'hB0B0_0000_0000_0002;
        rd_beats[2] = 64'hC0C0_0000_0000_0003; rd_beats[3] = 64'hD0D0_0000_0000_0004;
        exp_lines.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        obs_lines.delete();
        ifc.address_i = 32'h0000_2000;
        ifc.read_i    = 1'b1;
        mem_run(-1, 0, 1, 1'b1);
        if (obs_lines.size() > 0) begin
            gl = obs_lines.pop_front();
            total++; if (gl !== exp_lines[0]) begin bad++; $display("FAIL held_line_o: got %h want %h", gl, exp_lines[0]); end
        end else begin
            total++; bad++; $display("FAIL held_line_missing: got 0 lines want 1");
        end
        exp_lines.delete();
        // read_i was still high across the DONE edge; drop it now
        @(negedge clk);
        total++; if (ifc.read_o !== 1'b0) begin bad++; $display("FAIL held_no_rerun: got read_o=%b want 0", ifc.read_o); end
        ifc.read_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ifc.read_o !== 1'b0 || ifc.resp_o !== 1'b0) begin bad++; $display("FAIL held_idle%0d: got read_o=%b resp_o=%b want 0/0", i, ifc.read_o, ifc.resp_o); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] gl;
        ifc.address_i = 32'h0000_4444;
        ifc.read_i    = 1'b1;
        @(negedge clk);
        total++; if (ifc.read_o !== 1'b1) begin bad++; $display("FAIL rst_mid_read_start: got %b want 1", ifc.read_o); end
        for (int i = 0; i < 2; i++) begin
            ifc.resp_i  = 1'b1;
            ifc.burst_i = 64'hEEEE_0000_0000_0000 | 64'(i);
            @(negedge clk);
        end
        ifc.resp_i = 1'b0;
        ifc.read_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (ifc.read_o !== 1'b0 || ifc.resp_o !== 1'b0) begin bad++; $display("FAIL rst_mid_drop: got read_o=%b resp_o=%b want 0/0", ifc.read_o, ifc.resp_o); end
        rst = 1'b0;
        @(negedge clk);
        rd_beats[0] = 64'h0000_0000_0000_00A1; rd_beats[1] = 64'h0000_0000_0000_00B2;
        rd_beats[2] = 64'h0000_0000_0000_00C3; rd_beats[3] = 64'h0000_0000_0000_00D4;
        exp_lines.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        obs_lines.delete();
        ifc.read_i = 1'b1;
        mem_run(-1, 0, 1, 1'b0);
        total++; if (lat !== 6) begin bad++; $display("FAIL rst_mid_relatency: got %0d want 6", lat); end
        if (obs_lines.size() > 0) begin
            gl = obs_lines.pop_front();
            total++; if (gl !== exp_lines[0]) begin bad++; $display("FAIL rst_mid_line_o: got %h want %h", gl, exp_lines[0]); end
        end else begin
            total++; bad++; $display("FAIL rst_mid_line_missing: got 0 lines want 1");
        end
        exp_lines.delete();
        @(negedge clk);
    endtask

    task automatic test_spurious_resp();
        logic [255:0] prev;
        logic [255:0] gl;
        prev = {64'h0000_0000_0000_00D4, 64'h0000_0000_0000_00C3,
                64'h0000_0000_0000_00B2, 64'h0000_0000_0000_00A1};
        ifc.resp_i  = 1'b1;
        ifc.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ifc.line_o !== prev) begin bad++; $display("FAIL spur_line_o%0d: got %h want %h", i, ifc.line_o, prev); end
            total++; if (ifc.resp_o !== 1'b0 || ifc.read_o !== 1'b0) begin bad++; $display("FAIL spur_strobes%0d: got resp_o=%b read_o=%b want 0/0", i, ifc.resp_o, ifc.read_o); end
        end
        ifc.resp_i = 1'b0;
        rd_beats[0] = 64'h1357_9BDF_0000_0001; rd_beats[1] = 64'h2468_ACE0_0000_0002;
        rd_beats[2] = 64'h1357_9BDF_0000_0003; rd_beats[3] = 64'h2468_ACE0_0000_0004;
        exp_lines.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
        obs_lines.delete();
        ifc.address_i = 32'h0000_0080;
        ifc.read_i    = 1'b1;
        mem_run(-1, 0, 1, 1'b0);
        if (obs_lines.size() > 0) begin
            gl = obs_lines.pop_front();
            total++; if (gl !== exp_lines[0]) begin bad++; $display("FAIL spur_then_read: got %h want %h", gl, exp_lines[0]); end
        end else begin
            total++; bad++; $display("FAIL spur_read_missing: got 0 lines want 1");
        end
        exp_lines.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_b2b();
        test_write_stall();
        test_back_to_back();
        test_held_request();
        test_reset_mid_burst();
        test_spurious_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
